// File: rtl/rfx_vumeter_mc.sv
// rtl/rfx_vumeter_mc.sv - multi-channel VU/peak meter with AXI4-Lite register slave
// Per lane: decaying level, max-hold peak and sticky over-range flag, all software visible.
module rfx_vumeter_mc #(
    parameter int NCH                = 4,
    parameter int SAMPLE_W           = 16,
    parameter int DECAY_SHIFT        = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NCH*SAMPLE_W-1:0]         s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            ovr_irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int MW = SAMPLE_W - 1;
    localparam logic [AW-3:0] W_CTRL = (AW-2)'(0);
    localparam logic [AW-3:0] W_DIV  = (AW-2)'(1);
    localparam logic [AW-3:0] W_THR  = (AW-2)'(2);
    localparam logic [AW-3:0] W_OVR  = (AW-2)'(3);
    localparam logic [AW-3:0] W_LVL  = (AW-2)'(8);
    localparam logic [AW-3:0] W_PK   = (AW-2)'(16);

    logic                    wr_rdy_q, wr_rdy_d, bvalid_q, bvalid_d;
    logic                    ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
    logic [31:0]             rdata_q, rdata_d, rd_val;
    logic                    s_rdy_q, s_rdy_d;
    logic                    en_q, en_d, irq_q, irq_d;
    logic [31:0]             div_q, div_d, cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]     thr_q, thr_d;
    logic [NCH-1:0]          ovr_q, ovr_d, ovr_set, ovr_clr;
    logic [NCH-1:0][MW-1:0]  lvl_q, lvl_d, pk_q, pk_d, mag;
    logic [MW-1:0]           step, dec;
    logic [SAMPLE_W-1:0]     x, neg;
    logic                    wr_hs, rd_hs, wr_ctrl, wr_div, wr_thr, wr_ovr;
    logic                    peak_clr, evt, tick;
    logic [AW-3:0]           wword, rword, rbase;
    logic [2:0]              rch;
    logic                    unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    assign wr_hs    = wr_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs    = ar_rdy_q & S_AXI_ARVALID;
    assign wword    = S_AXI_AWADDR[AW-1:2];
    assign rword    = S_AXI_ARADDR[AW-1:2];
    assign rbase    = {rword[AW-3:3], 3'b000};
    assign rch      = rword[2:0];
    assign wr_ctrl  = wr_hs && (wword == W_CTRL);
    assign wr_div   = wr_hs && (wword == W_DIV);
    assign wr_thr   = wr_hs && (wword == W_THR);
    assign wr_ovr   = wr_hs && (wword == W_OVR);
    assign peak_clr = wr_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
    assign ovr_clr  = (wr_ovr && S_AXI_WSTRB[0]) ? S_AXI_WDATA[NCH-1:0] : '0;
    assign evt      = s_tvalid & s_rdy_q & en_q;
    assign tick     = en_q && (div_q != '0) && (cnt_q == div_q - 32'd1);
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // |x| with the most negative code saturated so it fits in SAMPLE_W-1 bits
    always_comb begin
        x   = '0;
        neg = '0;
        mag = '0;
        for (int i = 0; i < NCH; i++) begin
            x   = s_tdata[i*SAMPLE_W +: SAMPLE_W];
            neg = '0 - x;
            if (!x[SAMPLE_W-1])
                mag[i] = x[MW-1:0];
            else if (neg[SAMPLE_W-1])
                mag[i] = '1;
            else
                mag[i] = neg[MW-1:0];
        end
    end

    always_comb begin
        wr_rdy_d = ~wr_rdy_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
        bvalid_d = bvalid_q;
        if (wr_hs)
            bvalid_d = 1'b1;
        else if (S_AXI_BREADY)
            bvalid_d = 1'b0;
        ar_rdy_d = ~ar_rdy_q & ~rvalid_q & S_AXI_ARVALID;
        rvalid_d = rvalid_q;
        if (rd_hs)
            rvalid_d = 1'b1;
        else if (S_AXI_RREADY)
            rvalid_d = 1'b0;
        rdata_d = rd_hs ? rd_val : rdata_q;
        s_rdy_d = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (rword)
            W_CTRL:  rd_val = {31'b0, en_q};
            W_DIV:   rd_val = div_q;
            W_THR:   rd_val = 32'(thr_q);
            W_OVR:   rd_val = 32'(ovr_q);
            default: rd_val = '0;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (rbase == W_LVL && rch == 3'(i)) rd_val = 32'(lvl_q[i]);
            if (rbase == W_PK  && rch == 3'(i)) rd_val = 32'(pk_q[i]);
        end
    end

    always_comb begin
        en_d    = en_q;
        div_d   = div_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q + 32'd1;
        lvl_d   = lvl_q;
        pk_d    = pk_q;
        ovr_set = '0;
        step    = '0;
        dec     = '0;
        if (wr_ctrl && S_AXI_WSTRB[0]) en_d = S_AXI_WDATA[0];
        if (wr_div) div_d = merge(div_q, S_AXI_WDATA, S_AXI_WSTRB);
        if (wr_thr) thr_d = SAMPLE_W'(merge(32'(thr_q), S_AXI_WDATA, S_AXI_WSTRB));
        if (!en_q || div_q == '0 || tick || wr_div) cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            step = lvl_q[i] >> DECAY_SHIFT;
            if (step == '0) step = MW'(1);
            dec = (lvl_q[i] > step) ? lvl_q[i] - step : '0;
            lvl_d[i] = tick ? dec : lvl_q[i];
            if (evt && mag[i] > lvl_d[i]) lvl_d[i] = mag[i];
            // a clear in the same cycle as a sample wins; the sample is dropped from PEAK
            if (peak_clr)
                pk_d[i] = '0;
            else if (evt && mag[i] > pk_q[i])
                pk_d[i] = mag[i];
            ovr_set[i] = evt && (thr_q != '0) && ({1'b0, mag[i]} >= thr_q);
        end
        ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
        irq_d = |ovr_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            s_rdy_q  <= 1'b0;
            en_q     <= 1'b0;
            irq_q    <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            thr_q    <= '0;
            ovr_q    <= '0;
            lvl_q    <= '0;
            pk_q     <= '0;
        end else begin
            wr_rdy_q <= wr_rdy_d;
            bvalid_q <= bvalid_d;
            ar_rdy_q <= ar_rdy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            s_rdy_q  <= s_rdy_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            ovr_q    <= ovr_d;
            lvl_q    <= lvl_d;
            pk_q     <= pk_d;
        end
    end

    assign s_tready      = s_rdy_q;
    assign S_AXI_AWREADY = wr_rdy_q;
    assign S_AXI_WREADY  = wr_rdy_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_rdy_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign ovr_irq       = irq_q;

endmodule

// File: tb/tb_rfx_vumeter_mc.sv
// tb/tb_rfx_vumeter_mc.sv - self-checking bench for rfx_vumeter_mc
module tb_rfx_vumeter_mc;
    localparam int NCH = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [6:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic        ovr_irq;

    int checks = 0;
    int errors = 0;

    rfx_vumeter_mc dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .ovr_irq(ovr_irq)
    );

    always #5 ACLK = ~ACLK;

    // reference model: register state kept as plain integers
    int          m_lvl [NCH];
    int          m_pk  [NCH];
    logic [NCH-1:0] m_ovr;
    logic        m_en, m_irq;
    logic [31:0] m_div, m_cnt, m_thr;
    logic [31:0] exp_rd_q [$];

    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [6:0] a);
        int w;
        w = int'(a[6:2]);
        if (w == 0) return {31'b0, m_en};
        if (w == 1) return m_div;
        if (w == 2) return m_thr;
        if (w == 3) return 32'(m_ovr);
        if (w >= 8 && w < 8 + NCH) return 32'(m_lvl[w-8]);
        if (w >= 16 && w < 16 + NCH) return 32'(m_pk[w-16]);
        return 32'h0;
    endfunction

    always @(posedge ACLK or posedge ARESET) begin : model
        int a, d, st, wa;
        logic wr, evt, tk, pclr;
        logic [NCH-1:0] set_v, clr_v;
        if (ARESET) begin
            for (int i = 0; i < NCH; i++) begin
                m_lvl[i] <= 0;
                m_pk[i]  <= 0;
            end
            m_ovr <= '0; m_en <= 0; m_irq <= 0; m_div <= 0; m_cnt <= 0; m_thr <= 0;
            exp_rd_q.delete();
        end else begin
            wr = S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY;
            wa = int'(S_AXI_AWADDR[6:2]);
            if (S_AXI_ARVALID && S_AXI_ARREADY) exp_rd_q.push_back(mread(S_AXI_ARADDR));
            evt = s_tvalid && m_en;
            tk  = m_en && (m_div != 0) && (m_cnt == m_div - 1);
            if (!m_en || m_div == 0 || tk || (wr && wa == 1)) m_cnt <= 0;
            else m_cnt <= m_cnt + 1;
            clr_v = (wr && wa == 3 && S_AXI_WSTRB[0]) ? S_AXI_WDATA[NCH-1:0] : '0;
            pclr  = wr && wa == 0 && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
            set_v = '0;
            for (int i = 0; i < NCH; i++) begin
                a = mag(s_tdata[16*i +: 16]);
                d = m_lvl[i];
                if (tk) begin
                    st = d >> 4;
                    if (st < 1) st = 1;
                    d = d - st;
                    if (d < 0) d = 0;
                end
                if (evt && a > d) d = a;
                m_lvl[i] <= d;
                if (pclr) m_pk[i] <= 0;
                else if (evt && a > m_pk[i]) m_pk[i] <= a;
                if (evt && m_thr != 0 && a >= int'(m_thr)) set_v[i] = 1'b1;
            end
            m_ovr <= (m_ovr & ~clr_v) | set_v;
            m_irq <= (m_ovr != 0);
            if (wr && wa == 0 && S_AXI_WSTRB[0]) m_en <= S_AXI_WDATA[0];
            if (wr && wa == 1) m_div <= bmerge(m_div, S_AXI_WDATA, S_AXI_WSTRB);
            if (wr && wa == 2) m_thr <= bmerge(m_thr, S_AXI_WDATA, S_AXI_WSTRB) & 32'hFFFF;
        end
    end

    function automatic logic [63:0] lanes(input int l0, input int l1 = 0, input int l2 = 0,
                                          input int l3 = 0);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic send(input logic [63:0] v);
        s_tdata = v; s_tvalid = 1'b1;
        @(negedge ACLK);
        s_tvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic smp, input logic [63:0] sd, output logic [1:0] resp);
        int n;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        n = 0;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL aw_accept timeout addr=%h", a); end
        if (smp) begin s_tdata = sd; s_tvalid = 1; end
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        if (smp) s_tvalid = 0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL bvalid timeout addr=%h", a); end
        resp = S_AXI_BRESP;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, 1'b0, '0, r);
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output logic [31:0] exp);
        int n;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL ar_accept timeout addr=%h", a); end
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL rvalid timeout addr=%h", a); end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        @(negedge ACLK);
        S_AXI_RREADY = 0;
        exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 32'hxxxxxxxx;
    endtask

    task automatic do_reset();
        ARESET = 1;
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        logic [1:0]  r;
        ARESET = 1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, s_tready,
             ovr_irq, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero outputs while in reset, need 0");
        end
        ARESET = 0;
        repeat (2) @(negedge ACLK);
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL s_tready got %b need 1", s_tready); end
        for (int i = 0; i < 4; i++) begin
            axi_read(7'(4*i), got, r, exp);
            checks++;
            if (got !== 32'h0 || got !== exp || r !== 2'b00) begin
                errors++; $display("FAIL reset_reg %0h got %h resp %b need %h resp 00", 4*i, got, r, exp);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] got, exp;
        logic [1:0]  r;
        logic [6:0]  ra  [6] = '{7'h04, 7'h08, 7'h3C, 7'h5C, 7'h20, 7'h00};
        logic [31:0] req [6] = '{32'h01EEFFFF, 32'h0000ABCD, 0, 0, 0, 0};
        axi_write(7'h04, 32'h0101FFFF, 4'hF, 1'b0, '0, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL bresp_div got %b need 00", r); end
        axi_write(7'h08, 32'h0000ABCD, 4'hF, 1'b0, '0, r);
        axi_read(7'h04, got, r, exp);
        checks++;
        if (got !== 32'h0101FFFF || got !== exp) begin
            errors++; $display("FAIL div_readback got %h need %h", got, 32'h0101FFFF);
        end
        axi_write(7'h04, 32'h00EE0000, 4'b0100, 1'b0, '0, r);
        axi_write(7'h20, 32'h00001234, 4'hF, 1'b0, '0, r);
        axi_write(7'h00, 32'h00000002, 4'hF, 1'b0, '0, r);
        for (int i = 0; i < 6; i++) begin
            axi_read(ra[i], got, r, exp);
            checks++;
            if (got !== req[i] || got !== exp || r !== 2'b00) begin
                errors++; $display("FAIL reg_rd %h got %h resp %b need %h", ra[i], got, r, req[i]);
            end
        end
    endtask

    task automatic test_track();
        logic [31:0] got, exp;
        logic [1:0]  r;
        logic [6:0]  ra  [3] = '{7'h20, 7'h40, 7'h24};
        logic [31:0] req [3] = '{300, 300, 32767};
        do_reset();
        wr(7'h00, 1);
        send(lanes(100));
        send(lanes(-300, -32768));
        send(lanes(50));
        for (int i = 0; i < 3; i++) begin
            axi_read(ra[i], got, r, exp);
            checks++;
            if (got !== req[i] || got !== exp) begin
                errors++; $display("FAIL track %h got %0d need %0d", ra[i], got, req[i]);
            end
        end
    endtask

    task automatic test_decay();
        logic [31:0] got, exp;
        logic [1:0]  r;
        int          seq [$];
        int          obs [$];
        int          v;
        do_reset();
        wr(7'h00, 1);
        send(lanes(256));
        wr(7'h04, 10);
        v = 256;
        seq.push_back(v);
        while (v > 0) begin
            v = v - ((v >> 4) < 1 ? 1 : (v >> 4));
            if (v < 0) v = 0;
            seq.push_back(v);
        end
        for (int k = 0; k < 400; k++) begin
            axi_read(7'h20, got, r, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL decay_lvl got %0d need %0d", got, exp); end
            if (obs.size() == 0 || obs[$] != int'(got)) obs.push_back(int'(got));
            if (got == 0) break;
        end
        checks++;
        if (obs != seq) begin
            errors++;
            $display("FAIL decay_seq got %0d steps ending %0d need %0d steps", obs.size(), obs[$], seq.size());
        end
        axi_read(7'h40, got, r, exp);
        checks++;
        if (got !== 256 || got !== exp) begin errors++; $display("FAIL decay_peak got %0d need 256", got); end
    endtask

    task automatic test_peak_clr();
        logic [31:0] got, exp;
        logic [1:0]  r;
        logic [6:0]  ra  [3] = '{7'h40, 7'h20, 7'h00};
        logic [31:0] req [3] = '{0, 700, 1};
        do_reset();
        wr(7'h00, 1);
        send(lanes(500));
        axi_read(7'h40, got, r, exp);
        checks++;
        if (got !== 500 || got !== exp) begin errors++; $display("FAIL peak_pre got %0d need 500", got); end
        axi_write(7'h00, 32'h3, 4'hF, 1'b1, lanes(700), r);
        for (int i = 0; i < 3; i++) begin
            axi_read(ra[i], got, r, exp);
            checks++;
            if (got !== req[i] || got !== exp) begin
                errors++; $display("FAIL peak_clr %h got %0d need %0d", ra[i], got, req[i]);
            end
        end
        send(lanes(10));
        axi_read(7'h40, got, r, exp);
        checks++;
        if (got !== 10 || got !== exp) begin errors++; $display("FAIL peak_after got %0d need 10", got); end
    endtask

    task automatic test_ovr();
        logic [31:0] got, exp;
        logic [1:0]  r;
        wr(7'h08, 1000);
        send(lanes(999));
        axi_read(7'h0C, got, r, exp);
        checks++;
        if (got !== 0 || got !== exp) begin errors++; $display("FAIL ovr_999 got %h need 0", got); end
        send(lanes(0, 0, -1000));
        checks++;
        if (ovr_irq !== 1'b0 || ovr_irq !== m_irq) begin errors++; $display("FAIL irq_lag got %b need 0", ovr_irq); end
        @(negedge ACLK);
        checks++;
        if (ovr_irq !== 1'b1 || ovr_irq !== m_irq) begin errors++; $display("FAIL irq_set got %b need 1", ovr_irq); end
        axi_read(7'h0C, got, r, exp);
        checks++;
        if (got !== 4 || got !== exp) begin errors++; $display("FAIL ovr_set got %h need 4", got); end
        axi_write(7'h0C, 4, 4'hF, 1'b1, lanes(0, 0, -1500), r);
        axi_read(7'h0C, got, r, exp);
        checks++;
        if (got !== 4 || got !== exp) begin errors++; $display("FAIL ovr_setwins got %h need 4", got); end
        wr(7'h0C, 4);
        axi_read(7'h0C, got, r, exp);
        checks++;
        if (got !== 0 || got !== exp) begin errors++; $display("FAIL ovr_w1c got %h need 0", got); end
        checks++;
        if (ovr_irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b need 0", ovr_irq); end
    endtask

    task automatic test_handshake();
        logic [31:0] got, exp;
        logic [1:0]  r;
        int          acc;
        do_reset();
        wr(7'h00, 1);
        send(lanes(1234));
        S_AXI_AWADDR = 7'h08; S_AXI_WDATA = 77; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_BREADY = 0;
        repeat (3) begin
            @(negedge ACLK);
            checks++;
            if (S_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL aw_early got %b need 0", S_AXI_AWREADY); end
        end
        S_AXI_WVALID = 1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY && S_AXI_AWVALID && S_AXI_WVALID) acc++;
            else if (acc > 0) begin S_AXI_AWVALID = 0; S_AXI_WVALID = 0; end
        end
        checks++;
        if (acc != 1) begin errors++; $display("FAIL single_accept got %0d need 1", acc); end
        repeat (5) begin
            @(negedge ACLK);
            checks++;
            if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL bvalid_hold got %b need 1", S_AXI_BVALID); end
        end
        ARESET = 1;
        #1;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL bvalid_rst got %b need 0", S_AXI_BVALID); end
        @(negedge ACLK);
        ARESET = 0;
        S_AXI_BREADY = 1;
        repeat (4) @(negedge ACLK);
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL b_after_rst got %b need 0", S_AXI_BVALID); end
        S_AXI_BREADY = 0;
        for (int i = 0; i < 3; i++) begin
            axi_read(7'(i == 0 ? 8'h20 : (i == 1 ? 8'h40 : 8'h08)), got, r, exp);
            checks++;
            if (got !== 0 || got !== exp) begin errors++; $display("FAIL rst_clear %0d got %0d need 0", i, got); end
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        logic [1:0]  r;
        logic [6:0]  a;
        bit          run;
        do_reset();
        wr(7'h00, 1);
        wr(7'h08, $urandom_range(1, 20000));
        wr(7'h04, $urandom_range(0, 12));
        run = 1;
        fork
            begin
                while (run) begin
                    s_tvalid = 1'($urandom);
                    s_tdata  = {$urandom, $urandom};
                    @(negedge ACLK);
                end
                s_tvalid = 0;
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a = 7'(4 * $urandom_range(0, 3));
                        axi_write(a, (a == 0) ? ($urandom | 32'h1) : $urandom, 4'($urandom),
                                  1'b0, '0, r);
                    end else begin
                        a = 7'(4 * $urandom_range(0, 23));
                        axi_read(a, got, r, exp);
                        checks++;
                        if (got !== exp || r !== 2'b00) begin
                            errors++; $display("FAIL rand_rd %h got %h need %h", a, got, exp);
                        end
                    end
                end
                run = 0;
            end
        join
        @(negedge ACLK);
        checks++;
        if (ovr_irq !== m_irq) begin errors++; $display("FAIL rand_irq got %b need %b", ovr_irq, m_irq); end
    endtask

    initial begin
        @(negedge ACLK);
        test_reset();
        test_regs();
        test_track();
        test_decay();
        test_peak_clr();
        test_ovr();
        test_handshake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
